// File: rtl/tpu_pkg.sv
// Shared TPU types: the 80-bit instruction layout and its decode from raw bits.
`timescale 1ns/1ps
package tpu_pkg;

  localparam int INSTR_WIDTH    = 80;
  localparam int INSTR_SEGMENTS = 3;
  localparam int WORD_W         = 32;
  localparam int TAIL_W         = INSTR_WIDTH - 2 * WORD_W;

  typedef struct packed {
    logic [23:0] buffer_addr;
    logic [15:0] acc_addr;
    logic [31:0] length;
    logic [7:0]  opcode;
  } instr_type;

  typedef enum logic [1:0] {
    W0 = 2'd0,
    W1 = 2'd1,
    W2 = 2'd2
  } asm_state_t;

  function automatic instr_type bit_to_instr(input logic [INSTR_WIDTH-1:0] b);
    instr_type r;
    r.opcode      = b[7:0];
    r.length      = b[39:8];
    r.acc_addr    = b[55:40];
    r.buffer_addr = b[79:56];
    return r;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO of complete instructions; head entry is presented combinationally.
`timescale 1ns/1ps
module instr_fifo
  import tpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = INSTR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;
  logic             w_clear;

  assign w_clear = !rst_n || flush;
  assign full    = (r_level == LW'(DEPTH));
  assign empty   = (r_level == '0);
  assign level   = r_level;
  assign w_push  = push && !full && !w_clear;
  assign w_pop   = pop && !empty && !w_clear;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wdata;
  end

  // Storage is never reset; masking the head when empty keeps the output zero.
  assign rdata = empty ? '0 : r_mem[r_rptr];

endmodule

// File: rtl/instr_feeder.sv
// Assembles three 32-bit bus words into 80-bit instructions and queues them.
`timescale 1ns/1ps
module instr_feeder
  import tpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [31:0]                   in_word,
  input  logic                          in_valid,
  output logic                          in_ready,
  output instr_type                     out_instr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

  asm_state_t               r_state;
  asm_state_t               w_state_nxt;
  logic [2*WORD_W-1:0]      r_asm;
  logic                     w_accept;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_full;
  logic                     w_empty;
  logic [INSTR_WIDTH-1:0]   w_instr_bits;
  logic [INSTR_WIDTH-1:0]   w_head_bits;
  instr_type                w_instr;

  // in_ready depends only on state, fullness, reset and flush -- never on out_ready.
  always_comb begin
    in_ready = 1'b0;
    if (rst_n && !flush) begin
      in_ready = (r_state != W2) || !w_full;
    end
  end

  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && (r_state == W2);
  assign w_pop    = out_valid && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = W0;
    end else if (w_accept) begin
      case (r_state)
        W0:      w_state_nxt = W1;
        W1:      w_state_nxt = W2;
        W2:      w_state_nxt = W0;
        default: w_state_nxt = W0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= W0;
    else        r_state <= w_state_nxt;
  end

  // Partial words persist through any stall until the final segment arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_asm <= '0;
    end else if (w_accept) begin
      if (r_state == W0) r_asm[WORD_W-1:0]        <= in_word;
      if (r_state == W1) r_asm[2*WORD_W-1:WORD_W] <= in_word;
    end
  end

  assign w_instr_bits = {in_word[TAIL_W-1:0], r_asm};
  assign w_instr      = bit_to_instr(w_instr_bits);

  instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INSTR_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (w_push),
    .wdata (w_instr),
    .pop   (w_pop),
    .rdata (w_head_bits),
    .full  (w_full),
    .empty (w_empty),
    .level (fill_level)
  );

  assign out_valid = !w_empty;
  assign out_instr = w_head_bits;

endmodule

// File: tb/tb_instr_feeder.sv
// Randomised bench for instr_feeder against a word-grouping queue model.
`timescale 1ns/1ps
module tb_instr_feeder;
  import tpu_pkg::*;

  localparam int DEPTH = 4;

  logic                      clk;
  logic                      rst_n;
  logic                      flush;
  logic [31:0]               in_word;
  logic                      in_valid;
  logic                      in_ready;
  instr_type                 out_instr;
  logic                      out_valid;
  logic                      out_ready;
  logic [$clog2(DEPTH):0]    fill_level;

  int n_tests = 0;
  int n_fail  = 0;
  int dut_pops = 0;
  bit mon_en = 0;
  bit rnd_en = 0;

  instr_type   q[$];
  logic [31:0] parts[$];

  instr_feeder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_word    (in_word),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_instr  (out_instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fill_level (fill_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Field layout from the instruction format, computed arithmetically from the three words.
  function automatic instr_type mk(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    instr_type r;
    r.opcode      = 8'(w0 % 256);
    r.length      = 32'((w0 >> 8) + ((w1 % 256) << 24));
    r.acc_addr    = 16'((w1 >> 8) % 65536);
    r.buffer_addr = 24'((w1 >> 24) + ((w2 % 65536) << 8));
    return r;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_rdy;
      logic mpop;
      exp_rdy = rst_n && !flush && (parts.size() < 2 || q.size() < DEPTH);
      chk("in_ready", 80'(in_ready), 80'(exp_rdy));
      chk("fill_level", 80'(fill_level), 80'(q.size()));
      chk("out_valid", 80'(out_valid), 80'(q.size() != 0));
      if (q.size() != 0) chk("out_instr", out_instr, q[0]);
      if (out_valid && out_ready && rst_n && !flush) dut_pops++;
      if (!rst_n || flush) begin
        q.delete();
        parts.delete();
      end else begin
        mpop = out_ready && (q.size() != 0);
        if (mpop) void'(q.pop_front());
        if (in_valid && exp_rdy) begin
          parts.push_back(in_word);
          if (parts.size() == 3) begin
            q.push_back(mk(parts[0], parts[1], parts[2]));
            parts.delete();
          end
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] w);
    bit ok;
    ok = 0;
    in_word  = w;
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (rnd_en) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) chk("send_timeout", 80'(0), 80'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_instr(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    send_word(w0);
    send_word(w1);
    send_word(w2);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      if (rnd_en) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (fill_level == 0) break;
    end
    out_ready = 1'b0;
    chk("drain_level", 80'(fill_level), 80'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a0, a1, a2, b0, b1, b2, c0, c1, c2;
    int pops0;
    rst_n = 1'b0; flush = 1'b0; in_word = '0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    mon_en = 1;
    @(posedge clk); #1;
    chk("rst_fill", 80'(fill_level), 80'(0));
    chk("rst_out_valid", 80'(out_valid), 80'(0));
    chk("rst_out_instr", out_instr, 80'(0));
    chk("rst_in_ready", 80'(in_ready), 80'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single instruction
    send_instr(32'h0000_0001, 32'h0000_0002, 32'hFFFF_0003);
    chk("single_valid", 80'(out_valid), 80'(1));
    chk("single_opcode", 80'(out_instr.opcode), 80'(8'h01));
    chk("single_length", 80'(out_instr.length), 80'(32'h0200_0000));
    chk("single_acc", 80'(out_instr.acc_addr), 80'(16'h0000));
    chk("single_buf", 80'(out_instr.buffer_addr), 80'(24'h000300));
    chk("single_fill", 80'(fill_level), 80'(1));
    drain();

    // fill to full, then a 5th stalls in W2 until one pop
    for (int i = 0; i < DEPTH; i++) send_instr($urandom, $urandom, $urandom);
    chk("full_fill", 80'(fill_level), 80'(DEPTH));
    a0 = $urandom; a1 = $urandom; a2 = $urandom;
    send_word(a0);
    send_word(a1);
    in_word = a2; in_valid = 1'b1;
    @(negedge clk);
    chk("full_w2_rdy", 80'(in_ready), 80'(0));
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_rdy", 80'(in_ready), 80'(0));
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("after_pop_rdy", 80'(in_ready), 80'(1));
    chk("after_pop_fill", 80'(fill_level), 80'(DEPTH - 1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("fifth_fill", 80'(fill_level), 80'(DEPTH));
    drain();

    // simultaneous push and pop at fill_level 2
    a0 = $urandom; a1 = $urandom; a2 = $urandom;
    b0 = $urandom; b1 = $urandom; b2 = $urandom;
    c0 = $urandom; c1 = $urandom; c2 = $urandom;
    send_instr(a0, a1, a2);
    send_instr(b0, b1, b2);
    chk("sim_fill_pre", 80'(fill_level), 80'(2));
    send_word(c0);
    send_word(c1);
    in_word = c2; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("sim_fill_post", 80'(fill_level), 80'(2));
    chk("sim_head", out_instr, mk(b0, b1, b2));
    drain();

    // wrap-around with random back-pressure
    pops0 = dut_pops;
    rnd_en = 1;
    for (int i = 0; i < 10; i++) begin
      send_instr($urandom, $urandom, $urandom);
      idle($urandom_range(0, 3));
    end
    rnd_en = 0;
    drain();
    chk("wrap_pops", 80'(dut_pops - pops0), 80'(10));

    // flush mid-assembly
    send_word($urandom);
    send_word($urandom);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_fill", 80'(fill_level), 80'(0));
    a0 = $urandom; a1 = $urandom; a2 = $urandom;
    send_instr(a0, a1, a2);
    chk("flush_fill1", 80'(fill_level), 80'(1));
    chk("flush_instr", out_instr, mk(a0, a1, a2));
    drain();

    // reset during a stalled, partially assembled state
    for (int i = 0; i < 3; i++) send_instr($urandom, $urandom, $urandom);
    send_word($urandom);
    chk("pre_rst_fill", 80'(fill_level), 80'(3));
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mrst_fill", 80'(fill_level), 80'(0));
    chk("mrst_valid", 80'(out_valid), 80'(0));
    chk("mrst_instr", out_instr, 80'(0));
    chk("mrst_rdy", 80'(in_ready), 80'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    a0 = $urandom; a1 = $urandom; a2 = $urandom;
    send_instr(a0, a1, a2);
    chk("post_rst_instr", out_instr, mk(a0, a1, a2));
    chk("post_rst_fill", 80'(fill_level), 80'(1));
    drain();

    idle(2);
    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_feeder.md
INSTR_FEEDER -- requirements
Module: instr_feeder

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of complete instructions buffered; it must be a power of two and at least 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-004 The block SHALL have port flush, input, 1 bit: synchronous clear of the partial assembly and the FIFO.
REQ-005 The block SHALL have port in_word, input, 32 bits: the instruction word segment from the host bus.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_word is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts in_word this cycle.
REQ-008 The block SHALL have port out_instr, output, instr_type (80 bits): the head-of-FIFO instruction.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_instr is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream control unit consumes out_instr.
REQ-011 The block SHALL have port fill_level, output, $clog2(FIFO_DEPTH)+1 bits: the number of complete instructions stored.

Function
REQ-012 An input word SHALL be accepted on any cycle where in_valid && in_ready; an output SHALL be popped on any cycle where out_valid && out_ready.
REQ-013 Assembly SHALL use the FSM states W0, W1, W2; each accepted word advances W0->W1->W2->W0, and there is no advance without acceptance.
REQ-014 A word accepted in W0 SHALL supply bits[31:0] of the 80-bit instruction.
REQ-015 A word accepted in W1 SHALL supply bits[63:32].
REQ-016 A word accepted in W2 SHALL supply bits[79:64] from in_word[15:0]; in_word[31:16] SHALL be ignored.
REQ-017 On acceptance in W2, the assembled 80 bits SHALL be converted with bit_to_instr and written to the FIFO in that same cycle.
REQ-018 in_ready SHALL be 1 in W0 and W1 regardless of FIFO state.
REQ-019 In W2, in_ready SHALL equal !full; there is no combinational path from out_ready to in_ready.
REQ-020 The latency from the W2 acceptance edge to out_valid=1 with an empty FIFO SHALL be 1 cycle.
REQ-021 out_valid SHALL equal (fill_level != 0).
REQ-022 out_instr SHALL hold the oldest stored entry and SHALL be stable while out_valid && !out_ready.
REQ-023 A simultaneous push and pop SHALL leave fill_level unchanged.
REQ-024 When the FIFO is full, a push and pop in the same cycle SHALL NOT occur, because in_ready=0 in W2.
REQ-025 A pop SHALL be allowed while full.
REQ-026 A pop when empty SHALL be impossible because out_valid=0; out_ready alone SHALL have no effect.
REQ-027 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 full SHALL be (fill_level == FIFO_DEPTH).
REQ-029 When flush=1, the next state SHALL be W0, the pointers 0, fill_level 0 and out_valid 0, and any simultaneous push or pop SHALL be discarded.
REQ-030 While flush=1, in_ready SHALL be driven 0.
REQ-031 The partially assembled words SHALL be held across stalls indefinitely; there is no timeout.

Reset
REQ-032 When rst_n=0 at a clock edge, the block SHALL set: state W0; the assembly register 0; pointers 0; fill_level 0; out_valid 0; in_ready 0 during reset; out_instr all zero.
REQ-033 A reset during a partial assembly or a stalled output SHALL discard all content with no residual output.
REQ-034 Reset SHALL take priority over flush.

Structure
REQ-035 instr_type, bit_to_instr, and the new constants INSTR_WIDTH=80 and INSTR_SEGMENTS=3 SHALL reside in tpu_pkg.
REQ-036 The FIFO SHALL be a sub-module instr_fifo (synchronous, parameterised by depth and element type width, with push/pop/full/empty/level), instantiated once; the FSM and the assembly register stay in instr_feeder.

Verification
REQ-037 Bench scenario, single instruction: after reset, send 32'h0000_0001, 32'h0000_0002, 32'hFFFF_0003 with out_ready=0 -> one cycle later out_valid=1, opcode=8'h01, length=32'h0200_0000, acc_addr=16'h0000, buffer_addr=24'h000300, fill_level=1.
REQ-038 Bench scenario, fill to full: push 4 instructions with out_ready=0 -> fill_level=4, in_ready=1 in W0/W1 of the 5th, 0 in W2; raise out_ready for 1 cycle -> in_ready=1 next cycle, and the 5th completes.
REQ-039 Bench scenario, simultaneous push/pop: with fill_level=2, complete W2 while popping -> fill_level stays 2, order preserved (FIFO order matches the push order).
REQ-040 Bench scenario, wrap-around: stream 10 instructions with random out_ready -> all 10 emerge in order with exact field values, and no drops or duplicates.
REQ-041 Bench scenario, flush mid-assembly: accept 2 words, assert flush for 1 cycle, then send 3 fresh words -> exactly one instruction equal to the fresh words.
REQ-042 Bench scenario, reset mid-stall: with fill_level=3 and out_ready=0, pulse rst_n=0 -> next cycle fill_level=0, out_valid=0, out_instr=0, state W0.
